// File: rtl/paddle_ctrl.sv
// Paddle position controller: frame-rate button sampling,
// speed ramp while held, position clamped to the screen.
module paddle_ctrl #(
  parameter int HEIGHT       = 128,
  parameter int SCREEN_H     = 768,
  parameter int Y_INIT       = 320,
  parameter int MIN_SPEED    = 2,
  parameter int MAX_SPEED    = 12,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [9:0]  y,
  output logic        moving,
  output logic        frame_tick
);

  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int HW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [10:0] LIM = 11'(SCREEN_H - HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_up_m;
  logic          r_up_s;
  logic          r_dn_m;
  logic          r_dn_s;
  logic [SW-1:0] r_speed;
  logic [SW-1:0] w_speed_nx;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nx;
  logic [10:0]   w_y_ext;
  logic [10:0]   w_step;
  logic [10:0]   w_sum;
  logic [9:0]    w_y_nx;
  logic          w_tc;

  assign w_tc = (hcount == 11'd0) && (vcount == 10'(SCREEN_H));

  // Two-flop synchronisers for the raw buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      r_up_m <= 1'b0;
      r_up_s <= 1'b0;
      r_dn_m <= 1'b0;
      r_dn_s <= 1'b0;
    end else begin
      r_up_m <= btn_up;
      r_up_s <= r_up_m;
      r_dn_m <= btn_down;
      r_dn_s <= r_dn_m;
    end
  end

  // Direction decision: exactly one button selects a direction
  always_comb begin
    w_state_nx = IDLE;
    if (r_up_s && !r_dn_s) begin
      w_state_nx = UP;
    end else if (r_dn_s && !r_up_s) begin
      w_state_nx = DOWN;
    end
  end

  // Speed ramp: restart on any change, step up every ACCEL_FRAMES
  always_comb begin
    w_speed_nx = SW'(MIN_SPEED);
    w_hold_nx  = '0;
    if (w_state_nx != IDLE && w_state_nx == r_state) begin
      if (r_hold == HW'(ACCEL_FRAMES - 1)) begin
        w_hold_nx  = '0;
        w_speed_nx = (r_speed >= SW'(MAX_SPEED)) ?
                     SW'(MAX_SPEED) : r_speed + SW'(1);
      end else begin
        w_hold_nx  = r_hold + HW'(1);
        w_speed_nx = r_speed;
      end
    end
  end

  // Next position with saturation at both screen limits
  always_comb begin
    w_y_ext = {1'b0, y};
    w_step  = 11'(w_speed_nx);
    w_sum   = w_y_ext + w_step;
    w_y_nx  = y;
    case (w_state_nx)
      UP:      w_y_nx = (w_y_ext < w_step) ?
                        10'd0 : 10'(w_y_ext - w_step);
      DOWN:    w_y_nx = (w_sum > LIM) ? 10'(LIM) : 10'(w_sum);
      default: w_y_nx = y;
    endcase
  end

  // Frame-tick FSM: all state and outputs move together on tc
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_speed    <= SW'(MIN_SPEED);
      r_hold     <= '0;
      y          <= 10'(Y_INIT);
      moving     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_tc;
      if (w_tc) begin
        r_state <= w_state_nx;
        r_speed <= w_speed_nx;
        r_hold  <= w_hold_nx;
        y       <= w_y_nx;
        moving  <= (w_state_nx != IDLE);
      end
    end
  end

endmodule
